// File: rtl/ni_flit_tx.sv
`timescale 1ns/1ps
// ni_flit_tx: segments one packet descriptor into HEAD/BODY/TAIL (or HEADTAIL) flits on a round-robin VC.
// Head 2 edges after descriptor; per-VC on/off stalls body flits. Stats counters under NI_FLIT_TX_STATS_EN.

package ni_flit_pkg;
    localparam int VC_NUM            = 4;
    localparam int VC_SIZE           = $clog2(VC_NUM);
    localparam int DEST_ADDR_SIZE_X  = 2;
    localparam int DEST_ADDR_SIZE_Y  = 2;
    localparam int HEAD_PAYLOAD_SIZE = 16;
    localparam int FLIT_DATA_SIZE    = DEST_ADDR_SIZE_X + DEST_ADDR_SIZE_Y + HEAD_PAYLOAD_SIZE;

    typedef enum logic [1:0] {
        HEAD     = 2'b00,
        BODY     = 2'b01,
        TAIL     = 2'b10,
        HEADTAIL = 2'b11
    } flit_label_t;

    typedef struct packed {
        logic [DEST_ADDR_SIZE_X-1:0]  x_dest;
        logic [DEST_ADDR_SIZE_Y-1:0]  y_dest;
        logic [HEAD_PAYLOAD_SIZE-1:0] head_pl;
    } head_data_t;

    typedef union packed {
        head_data_t                head_data;
        logic [FLIT_DATA_SIZE-1:0] bt_pl;
    } flit_data_t;

    typedef struct packed {
        flit_label_t          flit_label;
        logic [VC_SIZE-1:0]   vc_id;
        flit_data_t           data;
    } flit_t;
endpackage

module ni_flit_tx
    import ni_flit_pkg::*;
#(
    parameter int MAX_PKT_LEN = 16,
    parameter int LEN_SIZE    = $clog2(MAX_PKT_LEN) + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pkt_valid_i,
    output logic                         pkt_ready_o,
    input  logic [DEST_ADDR_SIZE_X-1:0]  pkt_x_dest_i,
    input  logic [DEST_ADDR_SIZE_Y-1:0]  pkt_y_dest_i,
    input  logic [HEAD_PAYLOAD_SIZE-1:0] pkt_head_pl_i,
    input  logic [LEN_SIZE-1:0]          pkt_len_i,
    input  logic                         pl_valid_i,
    output logic                         pl_ready_o,
    input  logic [FLIT_DATA_SIZE-1:0]    pl_data_i,
    input  logic [VC_NUM-1:0]            on_off_i,
    input  logic [VC_NUM-1:0]            allocatable_i,
    output flit_t                        data_o,
    output logic                         valid_flit_o,
    output logic                         busy_o,
`ifdef NI_FLIT_TX_STATS_EN
    output logic [31:0]                  flit_cnt_o,
    output logic [31:0]                  stall_cnt_o,
`endif
    output logic                         error_o
);

    typedef enum logic [1:0] {S_IDLE, S_HEAD, S_BODY} state_t;

    state_t                       state_q;
    logic [DEST_ADDR_SIZE_X-1:0]  x_q;
    logic [DEST_ADDR_SIZE_Y-1:0]  y_q;
    logic [HEAD_PAYLOAD_SIZE-1:0] hpl_q;
    logic [LEN_SIZE-1:0]          len_q;
    logic [LEN_SIZE-1:0]          rem_q;
    logic [VC_SIZE-1:0]           cur_vc_q;
    logic [VC_SIZE-1:0]           rr_q;
    flit_t                        data_q;
    logic                         vld_q;
    logic                         err_q;

    // Scan downward so the last hit written is the one closest to ptr.
    function automatic logic [VC_SIZE:0] rr_pick(input logic [VC_NUM-1:0] el,
                                                  input logic [VC_SIZE-1:0] ptr);
        logic [VC_SIZE:0]   res;
        logic [VC_SIZE-1:0] idx;
        res = '0;
        for (int i = VC_NUM - 1; i >= 0; i--) begin
            idx = VC_SIZE'((int'(ptr) + i) % VC_NUM);
            if (el[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    logic [VC_SIZE:0]   pick;
    logic               pick_found;
    logic [VC_SIZE-1:0] pick_vc;
    logic [VC_SIZE-1:0] pick_vc_inc;
    logic               len_legal;
    logic               pkt_hs;
    logic               pl_hs;
    logic               flit_fire;

    assign pick        = rr_pick(on_off_i & allocatable_i, rr_q);
    assign pick_found  = pick[VC_SIZE];
    assign pick_vc     = pick[VC_SIZE-1:0];
    assign pick_vc_inc = (pick_vc == VC_SIZE'(VC_NUM - 1)) ? '0 : pick_vc + VC_SIZE'(1);
    assign len_legal   = (pkt_len_i != '0) && (pkt_len_i <= LEN_SIZE'(MAX_PKT_LEN));

    assign pkt_ready_o = (state_q == S_IDLE) & ~rst;
    // on_off is combinational into ready so a VC turning off blocks the handshake that same cycle.
    assign pl_ready_o  = (state_q == S_BODY) & on_off_i[cur_vc_q] & ~rst;
    assign pkt_hs      = pkt_valid_i & pkt_ready_o;
    assign pl_hs       = pl_valid_i & pl_ready_o;
    assign flit_fire   = ((state_q == S_HEAD) & pick_found) | pl_hs;

    assign data_o       = data_q;
    assign valid_flit_o = vld_q;
    assign error_o      = err_q;
    assign busy_o       = (state_q != S_IDLE) & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            hpl_q    <= '0;
            len_q    <= '0;
            rem_q    <= '0;
            cur_vc_q <= '0;
            rr_q     <= '0;
            data_q   <= '0;
            vld_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            vld_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pkt_hs) begin
                        x_q   <= pkt_x_dest_i;
                        y_q   <= pkt_y_dest_i;
                        hpl_q <= pkt_head_pl_i;
                        len_q <= pkt_len_i;
                        if (len_legal) state_q <= S_HEAD;
                        else           err_q   <= 1'b1;
                    end
                end
                S_HEAD: begin
                    if (pick_found) begin
                        cur_vc_q                  <= pick_vc;
                        rr_q                      <= pick_vc_inc;
                        vld_q                     <= 1'b1;
                        data_q.flit_label         <= (len_q == LEN_SIZE'(1)) ? HEADTAIL : HEAD;
                        data_q.vc_id              <= pick_vc;
                        data_q.data.head_data     <= '{x_dest: x_q, y_dest: y_q, head_pl: hpl_q};
                        rem_q                     <= len_q - LEN_SIZE'(1);
                        state_q                   <= (len_q == LEN_SIZE'(1)) ? S_IDLE : S_BODY;
                    end
                end
                S_BODY: begin
                    if (pl_hs) begin
                        vld_q             <= 1'b1;
                        data_q.flit_label <= (rem_q == LEN_SIZE'(1)) ? TAIL : BODY;
                        data_q.vc_id      <= cur_vc_q;
                        data_q.data.bt_pl <= pl_data_i;
                        rem_q             <= rem_q - LEN_SIZE'(1);
                        if (rem_q == LEN_SIZE'(1)) state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef NI_FLIT_TX_STATS_EN
    logic [31:0] flit_cnt_q;
    logic [31:0] stall_cnt_q;

    assign flit_cnt_o  = flit_cnt_q;
    assign stall_cnt_o = stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            flit_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (flit_fire && flit_cnt_q != '1)
                flit_cnt_q <= flit_cnt_q + 32'd1;
            if (state_q != S_IDLE && !flit_fire && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end
`endif

endmodule
